// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the raster timing source.
// Default mode is 1024x768@60 with a 65 MHz pixel clock.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 1024;
  localparam int DEF_H_FP     = 24;
  localparam int DEF_H_SYNC   = 136;
  localparam int DEF_H_BP     = 160;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 768;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 29;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Depth of the renderers' registered pixel pipeline; sync/blank are delayed to match.
  localparam int DEF_PIPE_DLY = 2;

  localparam int N_BARS = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Colour bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam rgb_t [0:N_BARS-1] COLOUR_BARS = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // Half-open window test on 12-bit widened positions: lo <= pos < hi.
  function automatic logic in_window(input logic [11:0] pos,
                                     input logic [11:0] lo,
                                     input logic [11:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register chain that aligns sync/blank (and optional pixel data)
// with the renderers' pipeline. DEPTH = 0 collapses to a wire.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             pixel_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_chain
      logic [DEPTH-1:0][WIDTH-1:0] stage;

      // Shift raw values one stage per pixel clock.
      // NOTE: every stage is reset, not just the last one: the chain must hold
      // inactive values so no stale sync pulse emerges after reset is released.
      always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
          stage <= {DEPTH{RST_VAL}};
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing source. hcount/vcount and the line/frame start
// pulses are undelayed; hsync/vsync/blank are delayed PIPE_DLY cycles to line up
// with the renderers' registered pixel output.
// Optional build macro: VGA_TEST_PATTERN_EN adds the tp_pixel colour-bar output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIPE_DLY = DEF_PIPE_DLY
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start,
  output logic        line_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output rgb_t        tp_pixel
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  // Decode thresholds widened to 12 bits so the H sums cannot overflow.
  localparam logic [11:0] H_ACT_W  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG_W = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END_W = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT_W  = 12'(V_ACTIVE);
  localparam logic [11:0] VS_BEG_W = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END_W = 12'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
  localparam int             BAR_W  = H_ACTIVE / N_BARS;
  localparam int             DL_W   = 3 + $bits(rgb_t);
  localparam logic [DL_W-1:0] DL_RST = {3'b111, 24'h000000};
`else
  localparam int             DL_W   = 3;
  localparam logic [DL_W-1:0] DL_RST = 3'b111;
`endif

  logic [11:0]     hc_w;
  logic [11:0]     vc_w;
  logic            hblank_r;
  logic            vblank_r;
  logic            blank_r;
  logic            hsync_r;
  logic            vsync_r;
  logic [DL_W-1:0] dl_in;
  logic [DL_W-1:0] dl_out;

  // Raster counters: hcount every cycle, vcount on each line wrap.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  assign hc_w = {1'b0, hcount};
  assign vc_w = {2'b00, vcount};

  // Raw (undelayed) sync and blank decodes; vsync edges fall on line boundaries.
  assign hblank_r = (hc_w >= H_ACT_W);
  assign vblank_r = (vc_w >= V_ACT_W);
  assign blank_r  = hblank_r | vblank_r;
  assign hsync_r  = ~in_window(hc_w, HS_BEG_W, HS_END_W);
  assign vsync_r  = ~in_window(vc_w, VS_BEG_W, VS_END_W);

  assign line_start  = (hcount == 11'd0);
  assign frame_start = (hcount == 11'd0) && (vcount == 10'd0);

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_idx;
  rgb_t       tp_r;

  // Pick the colour bar containing hcount; black outside the visible area.
  // NOTE: combinational outputs get a default first so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < N_BARS; i++) begin
      if (hc_w >= 12'(i * BAR_W)) begin
        bar_idx = 3'(i);
      end
    end
    tp_r = blank_r ? rgb_t'(24'h000000) : COLOUR_BARS[bar_idx];
  end

  assign dl_in = {hsync_r, vsync_r, blank_r, tp_r};
  assign {hsync, vsync, blank, tp_pixel} = dl_out;
`else
  assign dl_in = {hsync_r, vsync_r, blank_r};
  assign {hsync, vsync, blank} = dl_out;
`endif

  vga_delay_line #(
    .WIDTH   (DL_W),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (DL_RST)
  ) u_delay (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .din       (dl_in),
    .dout      (dl_out)
  );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-width 1024-pixel lines with a shortened
// vertical frame so several whole frames fit in a short run. Expected values
// come from the raster position (cycles since reset release) via plain arithmetic.
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 3;
  localparam int V_BP     = 2;
  localparam int PIPE     = 2;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic        pixel_clk;
  logic        reset_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic        frame_start;
  logic        line_start;
`ifdef VGA_TEST_PATTERN_EN
  logic [23:0] tp_pixel;
  logic [23:0] bar_tbl [8];
`endif

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  longint      k = 0;     // posedges since the last reset release
  int          ls_cnt;
  int          fs_cnt;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .PIPE_DLY (PIPE)
  ) dut (
    .pixel_clk   (pixel_clk),
    .reset_n     (reset_n),
    .hcount      (hcount),
    .vcount      (vcount),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank       (blank),
    .frame_start (frame_start),
    .line_start  (line_start)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .tp_pixel    (tp_pixel)
`endif
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  // ---- reference model: raster position -> expected signals ----
  function automatic int pos_h(input longint p);
    return int'(p % H_TOTAL);
  endfunction

  function automatic int pos_v(input longint p);
    return int'((p / H_TOTAL) % V_TOTAL);
  endfunction

  function automatic logic exp_hsync(input longint p);
    int h = pos_h(p);
    return !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
  endfunction

  function automatic logic exp_vsync(input longint p);
    int v = pos_v(p);
    return !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
  endfunction

  function automatic logic exp_blank(input longint p);
    return (pos_h(p) >= H_ACTIVE) || (pos_v(p) >= V_ACTIVE);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // Compare every output against the model at position k.
  task automatic check_running();
    longint p;
    chk("hcount", 32'(hcount), 32'(pos_h(k)));
    chk("vcount", 32'(vcount), 32'(pos_v(k)));
    chk("line_start", 32'(line_start), 32'(pos_h(k) == 0));
    chk("frame_start", 32'(frame_start), 32'(pos_h(k) == 0 && pos_v(k) == 0));
    if (k < PIPE) begin
      chk("hsync_fill", 32'(hsync), 32'd1);
      chk("vsync_fill", 32'(vsync), 32'd1);
      chk("blank_fill", 32'(blank), 32'd1);
`ifdef VGA_TEST_PATTERN_EN
      chk("tp_fill", 32'(tp_pixel), 32'd0);
`endif
    end else begin
      p = k - PIPE;
      chk("hsync", 32'(hsync), 32'(exp_hsync(p)));
      chk("vsync", 32'(vsync), 32'(exp_vsync(p)));
      chk("blank", 32'(blank), 32'(exp_blank(p)));
`ifdef VGA_TEST_PATTERN_EN
      chk("tp_pixel", 32'(tp_pixel),
          exp_blank(p) ? 32'd0 : 32'(bar_tbl[pos_h(p) / (H_ACTIVE / 8)]));
`endif
    end
  endtask

  task automatic check_reset();
    chk("rst_hcount", 32'(hcount), 32'd0);
    chk("rst_vcount", 32'(vcount), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_blank", 32'(blank), 32'd1);
`ifdef VGA_TEST_PATTERN_EN
    chk("rst_tp", 32'(tp_pixel), 32'd0);
`endif
  endtask

  // One pixel clock: advance the model, then sample mid-cycle.
  task automatic tick();
    @(posedge pixel_clk);
    k++;
    @(negedge pixel_clk);
    #1;
    check_running();
    if (line_start === 1'b1) ls_cnt++;
    if (frame_start === 1'b1) fs_cnt++;
  endtask

  // Assert reset away from the clock edge, hold, then release on a falling edge.
  task automatic pulse_reset(input int hold);
    @(negedge pixel_clk);
    reset_n = 1'b0;
    #1;
    check_reset();
    repeat (hold) @(negedge pixel_clk);
    #1;
    check_reset();
    @(negedge pixel_clk);
    reset_n = 1'b1;
    k = 0;
    #1;
    check_running();
  endtask

  initial begin
    int n;
`ifdef VGA_TEST_PATTERN_EN
    bar_tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif
    // Power-on reset and first release.
    reset_n = 1'b0;
    repeat (3) @(negedge pixel_clk);
    #1;
    check_reset();
    @(negedge pixel_clk);
    reset_n = 1'b1;
    k = 0;
    #1;
    check_running();

    // One full line: hcount 0..H_TOTAL-1 then 0, vcount steps to 1.
    ls_cnt = 0;
    repeat (H_TOTAL) tick();
    chk("line_wrap_h", 32'(hcount), 32'd0);
    chk("line_wrap_v", 32'(vcount), 32'd1);
    chk("line_start_count", 32'(ls_cnt), 32'd1);

    // Two whole frames: vcount wraps, frame_start once per frame.
    fs_cnt = 0;
    ls_cnt = 0;
    while (k < 2 * FRAME) tick();
    chk("frame_wrap_v", 32'(vcount), 32'd0);
    chk("frame_start_count", 32'(fs_cnt), 32'd2);
    chk("frame_line_count", 32'(ls_cnt), 32'(2 * V_TOTAL - 1));

    // Reset in the middle of an hsync pulse.
    n = 0;
    while (pos_h(k) != 1100 && n < H_TOTAL) begin
      tick();
      n++;
    end
    chk("pre_reset_hsync", 32'(hsync), 32'd0);
    pulse_reset(2);
    ls_cnt = 0;
    repeat (H_TOTAL) tick();
    chk("restart_line_start_count", 32'(ls_cnt), 32'd1);

    // Randomized run lengths and reset points.
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 2 * H_TOTAL));
      repeat (n) tick();
      pulse_reset(int'($urandom_range(1, 3)));
      repeat (int'($urandom_range(1, 8))) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
